// File: rtl/endpoint_link_port_if.sv
// Endpoint <-> switch-port attachment bundle.
// Groups the endpoint TX handshake, the link toward the switch, the RX
// path from the switch, the endpoint delivery handshake, credit pulses
// and debug/status outputs.
//   slave  : the endpoint_link_port block
//   master : whoever drives the endpoint/switch side (endpoint + switch port)
interface endpoint_link_port_if #(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_W      = 32
);
    localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int CRED_W = $clog2(BUFFER_SIZE + 1);

    // endpoint -> TX FIFOs
    logic                      tx_valid;
    logic [VC_W-1:0]           tx_vc;
    logic [FLIT_W-1:0]         tx_flit;
    logic                      tx_ready;
    // TX -> switch
    logic                      link_valid;
    logic [VC_W-1:0]           link_vc;
    logic [FLIT_W-1:0]         link_flit;
    logic [NUM_VCS-1:0]        credit_in;
    // switch -> RX FIFOs
    logic                      rx_valid;
    logic [VC_W-1:0]           rx_vc;
    logic [FLIT_W-1:0]         rx_flit;
    // RX FIFOs -> endpoint
    logic                      out_valid;
    logic [VC_W-1:0]           out_vc;
    logic [FLIT_W-1:0]         out_flit;
    logic                      out_ready;
    logic [NUM_VCS-1:0]        credit_out;
    // status
    logic [NUM_VCS*CRED_W-1:0] credits;
    logic [1:0]                err;

    modport slave (
        input  tx_valid, tx_vc, tx_flit, credit_in, rx_valid, rx_vc, rx_flit, out_ready,
        output tx_ready, link_valid, link_vc, link_flit, out_valid, out_vc, out_flit,
               credit_out, credits, err
    );

    modport master (
        output tx_valid, tx_vc, tx_flit, credit_in, rx_valid, rx_vc, rx_flit, out_ready,
        input  tx_ready, link_valid, link_vc, link_flit, out_valid, out_vc, out_flit,
               credit_out, credits, err
    );
endinterface

// File: rtl/endpoint_link_port.sv
// Endpoint-side attachment for one switch port.
// TX: per-VC FIFOs feed a round-robin arbiter gated by per-VC downstream
//     credit counters; one registered flit per cycle onto the link.
// RX: per-VC FIFOs drained round-robin to the endpoint; each consumed flit
//     returns a registered one-cycle credit pulse on its VC.
// Ports: clk, rst (async, active-high), bus (endpoint_link_port_if.slave):
//   tx_valid/tx_vc/tx_flit/tx_ready, link_valid/link_vc/link_flit, credit_in,
//   rx_valid/rx_vc/rx_flit, out_valid/out_vc/out_flit/out_ready,
//   credit_out, credits (live counters), err ([0] RX overflow, [1] credit overflow).
module endpoint_link_port #(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int TX_DEPTH    = 4,
    parameter int FLIT_W      = 32
) (
    input  logic clk,
    input  logic rst,
    endpoint_link_port_if.slave bus
);
    localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int CRED_W = $clog2(BUFFER_SIZE + 1);
    localparam int TX_AW  = $clog2(TX_DEPTH);
    localparam int RX_AW  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [VC_W:0]     NV       = (VC_W + 1)'(NUM_VCS);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_SIZE);

    typedef logic [FLIT_W-1:0] flit_t;

    flit_t              r_tx_mem [NUM_VCS][TX_DEPTH];
    logic [TX_AW:0]     r_tx_wp  [NUM_VCS];
    logic [TX_AW:0]     r_tx_rp  [NUM_VCS];
    logic [CRED_W-1:0]  r_cred   [NUM_VCS];
    logic [VC_W-1:0]    r_tx_rr;
    logic               r_link_valid;
    logic [VC_W-1:0]    r_link_vc;
    flit_t              r_link_flit;
    logic               r_err_cred;

    flit_t              r_rx_mem [NUM_VCS][BUFFER_SIZE];
    logic [RX_AW:0]     r_rx_wp  [NUM_VCS];   // {wrap, index}
    logic [RX_AW:0]     r_rx_rp  [NUM_VCS];
    logic [VC_W-1:0]    r_rx_rr;
    logic               r_rx_hold;
    logic [VC_W-1:0]    r_rx_hold_vc;
    logic [NUM_VCS-1:0] r_credit_out;
    logic               r_err_rx;

    logic [NUM_VCS-1:0] w_tx_empty, w_tx_full, w_tx_elig, w_send;
    logic [NUM_VCS-1:0] w_rx_empty, w_rx_full, w_rx_wr, w_rx_drop, w_rx_pop_v;
    logic               w_tx_ready, w_tx_push, w_tx_win, w_out_valid, w_rx_pop, w_rx_found;
    logic [VC_W-1:0]    w_tx_win_vc, w_rx_rr_vc, w_rx_sel;
    flit_t              w_tx_head;
    logic [NUM_VCS*CRED_W-1:0] w_credits;

    // First requester at or after ptr, wrapping; returns {found, vc}.
    function automatic logic [VC_W:0] rr_pick(input logic [NUM_VCS-1:0] req,
                                              input logic [VC_W-1:0]    ptr);
        logic [VC_W:0] idx;
        logic [VC_W:0] res;
        res = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            idx = {1'b0, ptr} + (VC_W + 1)'(i);
            if (idx >= NV) idx = idx - NV;
            if (!res[VC_W] && req[idx[VC_W-1:0]]) res = {1'b1, idx[VC_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
        return (v == VC_W'(NUM_VCS - 1)) ? '0 : v + VC_W'(1);
    endfunction

    // RX depth need not be a power of two, so the index wraps explicitly
    // and toggles the wrap bit.
    function automatic logic [RX_AW:0] rx_inc(input logic [RX_AW:0] p);
        if (p[RX_AW-1:0] == RX_AW'(BUFFER_SIZE - 1)) return {~p[RX_AW], {RX_AW{1'b0}}};
        return p + (RX_AW + 1)'(1);
    endfunction

    always_comb begin
        w_credits = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_tx_empty[v] = (r_tx_wp[v] == r_tx_rp[v]);
            w_tx_full[v]  = (r_tx_wp[v][TX_AW] != r_tx_rp[v][TX_AW]) &&
                            (r_tx_wp[v][TX_AW-1:0] == r_tx_rp[v][TX_AW-1:0]);
            w_tx_elig[v]  = !w_tx_empty[v] && (r_cred[v] != '0);
            w_rx_empty[v] = (r_rx_wp[v] == r_rx_rp[v]);
            w_rx_full[v]  = (r_rx_wp[v][RX_AW] != r_rx_rp[v][RX_AW]) &&
                            (r_rx_wp[v][RX_AW-1:0] == r_rx_rp[v][RX_AW-1:0]);
            w_credits[v*CRED_W +: CRED_W] = r_cred[v];
        end
    end

    always_comb begin
        w_tx_ready = 1'b0;
        for (int v = 0; v < NUM_VCS; v++)
            if (bus.tx_vc == VC_W'(v)) w_tx_ready = !w_tx_full[v];
    end
    assign w_tx_push = bus.tx_valid & w_tx_ready;

    assign {w_tx_win, w_tx_win_vc} = rr_pick(w_tx_elig, r_tx_rr);
    assign w_tx_head = r_tx_mem[w_tx_win_vc][r_tx_rp[w_tx_win_vc][TX_AW-1:0]];

    // While a presented flit waits for out_ready, keep offering the same VC
    // even if a flit arrives on a VC the pointer would now prefer.
    assign {w_rx_found, w_rx_rr_vc} = rr_pick(~w_rx_empty, r_rx_rr);
    assign w_rx_sel    = r_rx_hold ? r_rx_hold_vc : w_rx_rr_vc;
    assign w_out_valid = w_rx_found;
    assign w_rx_pop    = w_out_valid & bus.out_ready;

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_send[v]     = w_tx_win && (w_tx_win_vc == VC_W'(v));
            w_rx_pop_v[v] = w_rx_pop && (w_rx_sel == VC_W'(v));
            // a full FIFO still accepts when it is being drained this cycle
            w_rx_wr[v]    = bus.rx_valid && (bus.rx_vc == VC_W'(v)) && (!w_rx_full[v] || w_rx_pop_v[v]);
            w_rx_drop[v]  = bus.rx_valid && (bus.rx_vc == VC_W'(v)) && w_rx_full[v] && !w_rx_pop_v[v];
        end
    end

    // TX pointers, credits, link register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_tx_wp[v] <= '0;
                r_tx_rp[v] <= '0;
                r_cred[v]  <= CRED_MAX;
            end
            r_tx_rr      <= '0;
            r_link_valid <= 1'b0;
            r_link_vc    <= '0;
            r_link_flit  <= '0;
            r_err_cred   <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_tx_push && bus.tx_vc == VC_W'(v)) r_tx_wp[v] <= r_tx_wp[v] + (TX_AW + 1)'(1);
                if (w_send[v]) r_tx_rp[v] <= r_tx_rp[v] + (TX_AW + 1)'(1);
                if (w_send[v] && !bus.credit_in[v]) begin
                    r_cred[v] <= r_cred[v] - CRED_W'(1);
                end else if (!w_send[v] && bus.credit_in[v]) begin
                    if (r_cred[v] == CRED_MAX) r_err_cred <= 1'b1;
                    else                       r_cred[v]  <= r_cred[v] + CRED_W'(1);
                end
            end
            r_link_valid <= w_tx_win;
            if (w_tx_win) begin
                r_link_vc   <= w_tx_win_vc;
                r_link_flit <= w_tx_head;
                r_tx_rr     <= next_vc(w_tx_win_vc);
            end
        end
    end

    // RX pointers, delivery pointer, credit return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_rx_wp[v] <= '0;
                r_rx_rp[v] <= '0;
            end
            r_rx_rr      <= '0;
            r_rx_hold    <= 1'b0;
            r_rx_hold_vc <= '0;
            r_credit_out <= '0;
            r_err_rx     <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_rx_wr[v])    r_rx_wp[v] <= rx_inc(r_rx_wp[v]);
                if (w_rx_pop_v[v]) r_rx_rp[v] <= rx_inc(r_rx_rp[v]);
            end
            if (|w_rx_drop) r_err_rx <= 1'b1;
            r_credit_out <= w_rx_pop_v;
            r_rx_hold    <= w_out_valid & !bus.out_ready;
            r_rx_hold_vc <= w_rx_sel;
            if (w_rx_pop) r_rx_rr <= next_vc(w_rx_sel);
        end
    end

    // Storage arrays carry no reset; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (w_tx_push && bus.tx_vc == VC_W'(v)) r_tx_mem[v][r_tx_wp[v][TX_AW-1:0]] <= bus.tx_flit;
            if (w_rx_wr[v]) r_rx_mem[v][r_rx_wp[v][RX_AW-1:0]] <= bus.rx_flit;
        end
    end

    assign bus.tx_ready   = w_tx_ready;
    assign bus.link_valid = r_link_valid;
    assign bus.link_vc    = r_link_vc;
    assign bus.link_flit  = r_link_flit;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_vc     = w_rx_sel;
    assign bus.out_flit   = r_rx_mem[w_rx_sel][r_rx_rp[w_rx_sel][RX_AW-1:0]];
    assign bus.credit_out = r_credit_out;
    assign bus.credits    = w_credits;
    assign bus.err        = {r_err_cred, r_err_rx};
endmodule

// File: tb/tb_endpoint_link_port.sv
module tb_endpoint_link_port;
    localparam int NUM_VCS = 2, BUFFER_SIZE = 8, TX_DEPTH = 4, FLIT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    endpoint_link_port_if #(.NUM_VCS(NUM_VCS), .BUFFER_SIZE(BUFFER_SIZE), .FLIT_W(FLIT_W)) bus ();

    endpoint_link_port #(.NUM_VCS(NUM_VCS), .BUFFER_SIZE(BUFFER_SIZE), .TX_DEPTH(TX_DEPTH), .FLIT_W(FLIT_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        vc;
        logic [31:0] flit;
    } rx_exp_t;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] txq [NUM_VCS][$];
    rx_exp_t     rxq [$];
    logic        vclog [$];
    int          link_cnt = 0;
    int          cred_cnt = 0;
    logic        cap_hs;
    logic        cap_vc;
    logic [31:0] cap_flit;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture the endpoint handshake before the edge, then check
    // the registered link and credit_out against the scoreboards after it.
    task automatic step();
        logic [31:0]        e;
        rx_exp_t            r;
        logic [NUM_VCS-1:0] exp_co;
        @(negedge clk);
        cap_hs   = bus.out_valid & bus.out_ready;
        cap_vc   = bus.out_vc;
        cap_flit = bus.out_flit;
        @(posedge clk);
        #1;
        if (bus.link_valid === 1'b1) begin
            link_cnt++;
            vclog.push_back(bus.link_vc);
            nvec++;
            assert (txq[bus.link_vc].size() != 0) else begin
                nerr++;
                $error("FAIL link_unexpected observed=vc%0d/%0h expected=no flit", bus.link_vc, bus.link_flit);
            end
            if (txq[bus.link_vc].size() != 0) begin
                e = txq[bus.link_vc].pop_front();
                chk("link_flit", 64'(bus.link_flit), 64'(e));
            end
        end
        exp_co = '0;
        if (cap_hs) begin
            nvec++;
            assert (rxq.size() != 0) else begin
                nerr++;
                $error("FAIL out_unexpected observed=vc%0d/%0h expected=no flit", cap_vc, cap_flit);
            end
            if (rxq.size() != 0) begin
                r = rxq.pop_front();
                chk("out_flit", 64'({cap_vc, cap_flit}), 64'(r));
                exp_co[r.vc] = 1'b1;
            end
        end
        if (bus.credit_out != '0) cred_cnt++;
        chk("credit_out", 64'(bus.credit_out), 64'(exp_co));
    endtask

    task automatic push(input logic vc, input logic [31:0] f);
        bit done;
        done = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_vc    = vc;
        bus.tx_flit  = f;
        for (int t = 0; t < 64 && !done; t++) begin
            #1;
            done = bus.tx_ready;
            if (done) txq[vc].push_back(f);
            step();
        end
        bus.tx_valid = 1'b0;
        if (!done) chk("push_timeout", 64'(done), 64'(1));
    endtask

    task automatic rx_send(input logic vc, input logic [31:0] f, input bit expect_kept);
        bus.rx_valid = 1'b1;
        bus.rx_vc    = vc;
        bus.rx_flit  = f;
        if (expect_kept) rxq.push_back('{vc: vc, flit: f});
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.credit_in = '0;
        #1;
        for (int v = 0; v < NUM_VCS; v++) txq[v].delete();
        rxq.delete();
        step();
        step();
        rst = 1'b0;
        step();
        link_cnt = 0;
        cred_cnt = 0;
        vclog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        bus.tx_valid  = 1'b0;
        bus.tx_vc     = '0;
        bus.tx_flit   = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_vc     = '0;
        bus.rx_flit   = '0;
        bus.out_ready = 1'b0;
        bus.credit_in = '0;

        // reset state
        step();
        step();
        chk("rst_link_valid", 64'(bus.link_valid), 64'(0));
        chk("rst_link_vc",    64'(bus.link_vc),    64'(0));
        chk("rst_link_flit",  64'(bus.link_flit),  64'(0));
        chk("rst_credit_out", 64'(bus.credit_out), 64'(0));
        chk("rst_err",        64'(bus.err),        64'(0));
        chk("rst_out_valid",  64'(bus.out_valid),  64'(0));
        chk("rst_credits",    64'(bus.credits),    64'h88);
        chk("rst_tx_ready",   64'(bus.tx_ready),   64'(1));
        rst = 1'b0;
        step();

        // 3 flits on VC0: two-cycle latency, three link cycles
        push(1'b0, 32'hA000_0001);
        chk("t1_lat_edge1", 64'(bus.link_valid), 64'(0));
        push(1'b0, 32'hA000_0002);
        chk("t1_first",     64'(bus.link_valid), 64'(1));
        push(1'b0, 32'hA000_0003);
        chk("t1_second",    64'(bus.link_valid), 64'(1));
        step();
        chk("t1_third",     64'(bus.link_valid), 64'(1));
        step();
        chk("t1_done",      64'(bus.link_valid), 64'(0));
        chk("t1_count",     64'(link_cnt),       64'(3));
        chk("t1_credits",   64'(bus.credits),    64'h85);
        chk("t1_err",       64'(bus.err),        64'(0));

        // 10 flits on VC0, no credit return: 8 go, then one more per credit
        do_reset();
        for (int i = 0; i < 10; i++) push(1'b0, 32'(200 + i));
        repeat (6) step();
        chk("t2_sent8",     64'(link_cnt),    64'(8));
        chk("t2_cred0",     64'(bus.credits), 64'h80);
        bus.credit_in = 2'b01;
        step();
        bus.credit_in = 2'b00;
        chk("t2_cred_back", 64'(bus.credits),    64'h81);
        chk("t2_not_yet",   64'(bus.link_valid), 64'(0));
        step();
        chk("t2_ninth",     64'(bus.link_valid), 64'(1));
        chk("t2_cred_zero", 64'(bus.credits),    64'h80);
        step();
        chk("t2_stalled",   64'(link_cnt),       64'(9));

        // exhaust both VCs' credit, queue 4+4, then return credit in parallel
        do_reset();
        for (int i = 0; i < 16; i++) push(1'(i % 2), 32'(300 + i));
        repeat (3) step();
        chk("t3_drained",   64'(bus.credits), 64'h00);
        for (int i = 0; i < 4; i++) push(1'b0, 32'(400 + i));
        for (int i = 0; i < 4; i++) push(1'b1, 32'(410 + i));
        vclog.delete();
        link_cnt = 0;
        bus.credit_in = 2'b11;
        repeat (4) step();
        bus.credit_in = 2'b00;
        repeat (10) step();
        chk("t3_rr_count",  64'(link_cnt), 64'(8));
        pat = '0;
        for (int i = 0; i < 8 && i < vclog.size(); i++) pat[i] = vclog[i];
        chk("t3_rr_order",  64'(pat), 64'hAA);
        chk("t3_cred_end",  64'(bus.credits), 64'h00);
        // VC0 starved of credit, VC1 given 3: only VC1 moves
        vclog.delete();
        link_cnt = 0;
        push(1'b0, 32'h0000_0500);
        push(1'b0, 32'h0000_0501);
        for (int i = 0; i < 3; i++) push(1'b1, 32'(510 + i));
        bus.credit_in = 2'b10;
        repeat (3) step();
        bus.credit_in = 2'b00;
        repeat (6) step();
        chk("t3_vc1_count", 64'(link_cnt), 64'(3));
        pat = '0;
        for (int i = 0; i < vclog.size() && i < 8; i++) pat[i] = vclog[i];
        chk("t3_vc1_only",  64'(pat), 64'h07);
        chk("t3_vc0_held",  64'(txq[0].size()), 64'(2));

        // send + credit same cycle, then credit at full count
        do_reset();
        push(1'b1, 32'h0000_0600);
        bus.credit_in = 2'b10;
        step();
        bus.credit_in = 2'b00;
        chk("t4_sent",      64'({bus.link_valid, bus.link_vc}), 64'(3));
        chk("t4_cred_same", 64'(bus.credits), 64'h88);
        chk("t4_no_err",    64'(bus.err),     64'(0));
        bus.credit_in = 2'b10;
        step();
        bus.credit_in = 2'b00;
        chk("t4_cred_sat",  64'(bus.credits), 64'h88);
        chk("t4_err_cred",  64'(bus.err),     64'(2));

        // RX overflow on VC1 then in-order drain with credit pulses
        do_reset();
        for (int i = 0; i < 9; i++) rx_send(1'b1, 32'(700 + i), i < 8);
        chk("t5_err_rx",    64'(bus.err),       64'(1));
        chk("t5_out_valid", 64'(bus.out_valid), 64'(1));
        chk("t5_out_head",  64'({bus.out_vc, bus.out_flit}), 64'({1'b1, 32'(700)}));
        bus.out_ready = 1'b1;
        for (int t = 0; t < 20 && rxq.size() != 0; t++) step();
        bus.out_ready = 1'b0;
        step();
        chk("t5_drained",   64'(rxq.size()),    64'(0));
        chk("t5_pulses",    64'(cred_cnt),      64'(8));
        chk("t5_empty",     64'(bus.out_valid), 64'(0));

        // selection held while waiting, even when a preferred VC arrives
        do_reset();
        rx_send(1'b1, 32'h0000_0800, 1'b1);
        rx_send(1'b0, 32'h0000_0801, 1'b1);
        chk("t5_hold_vc",   64'(bus.out_vc), 64'(1));
        bus.out_ready = 1'b1;
        for (int t = 0; t < 8 && rxq.size() != 0; t++) step();
        bus.out_ready = 1'b0;
        step();
        chk("t5_hold_drain", 64'(rxq.size()), 64'(0));

        // reset with TX and RX flits queued
        do_reset();
        for (int i = 0; i < 8; i++) push(1'b0, 32'(900 + i));
        for (int i = 0; i < 3; i++) push(1'b0, 32'(910 + i));
        rx_send(1'b1, 32'h0000_0920, 1'b1);
        rx_send(1'b1, 32'h0000_0921, 1'b1);
        repeat (2) step();
        chk("t6_pre_out",   64'(bus.out_valid), 64'(1));
        chk("t6_pre_cred",  64'(bus.credits),   64'h80);
        rst = 1'b1;
        #1;
        chk("t6_link_valid", 64'(bus.link_valid), 64'(0));
        chk("t6_out_valid",  64'(bus.out_valid),  64'(0));
        chk("t6_credit_out", 64'(bus.credit_out), 64'(0));
        chk("t6_credits",    64'(bus.credits),    64'h88);
        chk("t6_err",        64'(bus.err),        64'(0));
        for (int v = 0; v < NUM_VCS; v++) txq[v].delete();
        rxq.delete();
        step();
        rst = 1'b0;
        link_cnt = 0;
        cred_cnt = 0;
        bus.out_ready = 1'b1;
        repeat (5) step();
        bus.out_ready = 1'b0;
        chk("t6_no_link",    64'(link_cnt),      64'(0));
        chk("t6_no_pulses",  64'(cred_cnt),      64'(0));
        chk("t6_still_empty", 64'(bus.out_valid), 64'(0));
        chk("t6_cred_kept",  64'(bus.credits),   64'h88);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
